// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB register-bank slave.
// Optional byte-lane strobes are enabled with APB_PSTRB_EN.
package apb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } apb_slv_state_e;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  function automatic logic [APB_DATA_W-1:0] strb_mask(
    input logic [APB_STRB_W-1:0] s
  );
    logic [APB_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < APB_STRB_W; i++) begin
      m[8*i +: 8] = {8{s[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: byte address to word index plus illegal-access flag.
// Flags misalignment, out-of-range and writes to the read-only counter.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  localparam int IW = $clog2(NUM_REGS)
) (
  input  logic [31:0]   paddr,
  input  logic          pwrite,
  output logic [IW-1:0] idx,
  output logic          err
);

  // decode index and error in one combinational step
  always_comb begin
    idx = paddr[IW+1:2];
    err = (paddr[1:0] != 2'b00)
        | (paddr >= 32'(NUM_REGS * 4))
        | (pwrite & (idx == IW'(NUM_REGS - 1)));
  end

endmodule

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB completer with a register bank, wait states
// and a read-only transfer counter in the top slot. Macro: APB_PSTRB_EN.
module apb_regbank_slave
  import apb_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int DATA_W      = APB_DATA_W
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [DATA_W-1:0] pwdata,
`ifdef APB_PSTRB_EN
  input  logic [APB_STRB_W-1:0] pstrb,
`endif
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

  apb_slv_state_e    state;
  logic [3:0]        wcnt;
  logic              pen_q;
  logic              wr_q;
  logic              err_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [APB_STRB_W-1:0] strb_q;
  logic [DATA_W-1:0] regs [NUM_REGS-1];
  logic [DATA_W-1:0] xfer_cnt;

  logic [IW-1:0]     dec_idx;
  logic              dec_err;
  logic              start;
  logic [IW-1:0]     cur_idx;
  logic              cur_err;
  logic              cur_wr;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rsp_data;
  logic [APB_STRB_W-1:0] strb_in;
  logic [DATA_W-1:0] wmask;

  apb_addr_decode #(
    .NUM_REGS(NUM_REGS)
  ) u_dec (
    .paddr (paddr),
    .pwrite(pwrite),
    .idx   (dec_idx),
    .err   (dec_err)
  );

  // access start, response data source and write mask
  always_comb begin
`ifdef APB_PSTRB_EN
    strb_in = pstrb;
`else
    strb_in = '1;
`endif
    start   = (state == S_IDLE) & psel & penable & ~pen_q;
    cur_idx = (state == S_IDLE) ? dec_idx : idx_q;
    cur_err = (state == S_IDLE) ? dec_err : err_q;
    cur_wr  = (state == S_IDLE) ? pwrite  : wr_q;
    rd_val  = (cur_idx == LAST) ? xfer_cnt : regs[cur_idx];
    if (cur_wr)
      rsp_data = prdata;
    else if (cur_err)
      rsp_data = '0;
    else
      rsp_data = rd_val;
    wmask = strb_mask(strb_q);
  end

  // transfer FSM, register bank and counter
  always_ff @(posedge pclk) begin
    if (prst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      pen_q    <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      xfer_cnt <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      for (int i = 0; i < NUM_REGS - 1; i++)
        regs[i] <= '0;
    end else begin
      pen_q <= penable;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            idx_q   <= dec_idx;
            err_q   <= dec_err;
            wr_q    <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= strb_in;
            if (WAIT_CYCLES == 0) begin
              state   <= S_RESP;
              pready  <= 1'b1;
              pslverr <= cur_err;
              prdata  <= rsp_data;
            end else begin
              state <= S_WAIT;
              wcnt  <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          if (wcnt <= 4'd1) begin
            state   <= S_RESP;
            pready  <= 1'b1;
            pslverr <= cur_err;
            prdata  <= rsp_data;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          pready   <= 1'b0;
          pslverr  <= 1'b0;
          xfer_cnt <= xfer_cnt + 1'b1;
          if (wr_q && !err_q)
            regs[idx_q] <= (regs[idx_q] & ~wmask) | (wdata_q & wmask);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb_apb_regbank_slave: directed vectors on a shared APB bus driving
// two slaves, one with WAIT_CYCLES=1 and one with WAIT_CYCLES=0.
module tb_apb_regbank_slave;

  logic        pclk = 1'b0;
  logic        prst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic        pready1, pslverr1;
  logic [31:0] prdata1;
  logic        pready0, pslverr0;
  logic [31:0] prdata0;

  int n_vec = 0;
  int n_err = 0;

  int          lat0, lat1, np0, np1;
  logic        er0, er1;
  logic [31:0] rd0, rd1;

  always #5 pclk = ~pclk;

  apb_regbank_slave #(.NUM_REGS(32), .WAIT_CYCLES(1)) dut1 (
    .pclk   (pclk),
    .prst   (prst),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
`ifdef APB_PSTRB_EN
    .pstrb  (pstrb),
`endif
    .pready (pready1),
    .prdata (prdata1),
    .pslverr(pslverr1)
  );

  apb_regbank_slave #(.NUM_REGS(32), .WAIT_CYCLES(0)) dut0 (
    .pclk   (pclk),
    .prst   (prst),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
`ifdef APB_PSTRB_EN
    .pstrb  (pstrb),
`endif
    .pready (pready0),
    .prdata (prdata0),
    .pslverr(pslverr0)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // setup + access, inputs scrambled after T, penable held long
  task automatic xfer(input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge pclk);
    penable = 1'b1;
    lat0 = 0; lat1 = 0; np0 = 0; np1 = 0;
    er0 = 1'bx; er1 = 1'bx; rd0 = 'x; rd1 = 'x;
    for (int k = 1; k <= 6; k++) begin
      @(negedge pclk);
      if (pready0) begin
        np0++;
        if (lat0 == 0) begin lat0 = k; er0 = pslverr0; rd0 = prdata0; end
      end
      if (pready1) begin
        np1++;
        if (lat1 == 0) begin lat1 = k; er1 = pslverr1; rd1 = prdata1; end
      end
      if (k == 1) begin
        paddr = 32'hFFFF_FFFC; pwdata = ~d; pwrite = ~wr; pstrb = ~s;
      end
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
  endtask

  task automatic run(input string tag, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic exp_err,
                     input logic [31:0] exp_data);
    xfer(wr, a, d, s);
    check({tag, " lat1"}, 32'(lat1), 32'd2);
    check({tag, " lat0"}, 32'(lat0), 32'd1);
    check({tag, " pulses1"}, 32'(np1), 32'd1);
    check({tag, " pulses0"}, 32'(np0), 32'd1);
    check({tag, " err1"}, 32'(er1), 32'(exp_err));
    check({tag, " err0"}, 32'(er0), 32'(exp_err));
    if (!wr) begin
      check({tag, " rdata1"}, rd1, exp_data);
      check({tag, " rdata0"}, rd0, exp_data);
    end
  endtask

  initial begin
    prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = 4'hF;
    repeat (3) @(negedge pclk);
    check("rst pready1", 32'(pready1), 32'd0);
    check("rst pslverr1", 32'(pslverr1), 32'd0);
    check("rst prdata1", prdata1, 32'd0);
    check("rst pready0", 32'(pready0), 32'd0);
    check("rst pslverr0", 32'(pslverr0), 32'd0);
    check("rst prdata0", prdata0, 32'd0);
    prst = 1'b0;
    @(negedge pclk);

    run("w08", 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    run("r08", 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF);
    run("r03", 1'b0, 32'h03, 32'h0, 4'hF, 1'b1, 32'h0);
    run("w200", 1'b1, 32'h200, 32'h5555_AAAA, 4'hF, 1'b1, 32'h0);
    run("w7c", 1'b1, 32'h7C, 32'h1234, 4'hF, 1'b1, 32'h0);
    run("rcnt5", 1'b0, 32'h7C, 32'h0, 4'hF, 1'b0, 32'd5);
    run("r00", 1'b0, 32'h00, 32'h0, 4'hF, 1'b0, 32'h0);
    run("r78", 1'b0, 32'h78, 32'h0, 4'hF, 1'b0, 32'h0);
    run("rcnt8", 1'b0, 32'h7C, 32'h0, 4'hF, 1'b0, 32'd8);
    run("w10", 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0);
    run("r10", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hA5A5_A5A5);
    @(negedge pclk);
    check("hold prdata1", prdata1, 32'hA5A5_A5A5);
    check("hold prdata0", prdata0, 32'hA5A5_A5A5);
    run("w14", 1'b1, 32'h14, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0);
    check("wr hold prdata1", prdata1, 32'hA5A5_A5A5);

`ifdef APB_PSTRB_EN
    run("w0c", 1'b1, 32'h0C, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
    run("w0c strb", 1'b1, 32'h0C, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
    run("r0c strb", 1'b0, 32'h0C, 32'h0, 4'h0, 1'b0, 32'h11BB_33DD);
    run("w0c s0", 1'b1, 32'h0C, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0);
    run("r0c s0", 1'b0, 32'h0C, 32'h0, 4'hF, 1'b0, 32'h11BB_33DD);
`endif

    // reset while the WAIT_CYCLES=1 slave sits in S_WAIT
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h04; pwdata = 32'hFFFF_0000; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    check("abort wait pready1", 32'(pready1), 32'd0);
    prst = 1'b1;
    @(negedge pclk);
    check("abort rst pready1", 32'(pready1), 32'd0);
    prst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge pclk);
    check("abort post pready1", 32'(pready1), 32'd0);
    run("abort rcnt", 1'b0, 32'h7C, 32'h0, 4'hF, 1'b0, 32'd0);
    run("abort r04", 1'b0, 32'h04, 32'h0, 4'hF, 1'b0, 32'h0);
    run("abort r10", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb_regbank_slave.md
Name: apb_regbank_slave

Overview:
- APB completer (slave) sitting directly downstream of the APB master FSM; consumes psel/penable/pwrite/paddr/pwdata and returns pready/prdata/pslverr.
- Holds a bank of NUM_REGS 32-bit registers. The top register is a read-only counter of completed transfers.
- Inserts a programmable number of wait states and flags illegal accesses with pslverr.

Parameters:
- NUM_REGS, 32, number of word registers (power of 2, ≥4); index NUM_REGS-1 is the read-only transfer counter.
- WAIT_CYCLES, 1, wait states inserted before pready (0..15).
- DATA_W, 32, data width (fixed at 32; byte lanes assume 4).

Ports:
- pclk  in  1  clock, all logic on rising edge.
- prst  in  1  reset, synchronous, active-high.
- psel  in  1  slave select from master.
- penable  in  1  access-phase strobe from master.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  32  byte address.
- pwdata  in  32  write data.
- pready  out  1  transfer complete, one-cycle pulse.
- prdata  out  32  read data, valid when pready=1 and pwrite=0.
- pslverr  out  1  error response, valid only with pready.

Behaviour:
- Reset (prst=1 at a clock edge): pready=0, pslverr=0, prdata=0, all registers=0, transfer counter=0, FSM to S_IDLE. Reset mid-transfer aborts it with no write committed and no pready.
- Access start: in S_IDLE, psel=1 and penable=1 with penable=0 on the previous cycle (rising edge of access phase, cycle T). Inputs are sampled at T; later input changes are ignored until RESP.
- FSM states:
  - S_IDLE: on start, go to S_WAIT with wait counter = WAIT_CYCLES. If WAIT_CYCLES=0, go directly to S_RESP.
  - S_WAIT: decrement the counter each cycle; go to S_RESP when it reaches 1.
  - S_RESP: pready=1 for exactly one cycle, then S_IDLE.
- Latency: pready high in cycle T+1+WAIT_CYCLES. With WAIT_CYCLES=0, pready is high at T+1.
- Decode: word index = paddr[log2(NUM_REGS)+1:2].
  - pslverr=1 if paddr[1:0]≠0.
  - pslverr=1 if paddr ≥ NUM_REGS*4.
  - pslverr=1 for a write to index NUM_REGS-1.
- Write, no error: register updated on the S_RESP clock edge. It is readable from the next access onward.
- Read, no error: prdata = register value, driven in the S_RESP cycle.
- Read with error: prdata = 0.
- prdata holds its last value outside S_RESP.
- Write with error: no register modified.
- pslverr = 0 whenever pready = 0.
- Transfer counter: +1 on every S_RESP cycle (including errored transfers); wraps 0xFFFFFFFF → 0.
  - A read of the counter returns its value before that transfer's increment.
- psel dropped during S_WAIT: the transfer still completes. Protocol violation; no special handling.
- penable held high after pready: no new access until penable returns low (edge rule).

Optional Feature:
- APB_PSTRB_EN:
  - Defined: adds input pstrb[3:0]. A write updates only the byte lanes with pstrb bit = 1. pstrb=0 on a write is legal (no change, no error). Reads ignore pstrb.
  - Undefined: the port is absent and all four lanes are always written.

Decomposition:
- Package apb_pkg holds:
  - state enum apb_slv_state_e {S_IDLE, S_WAIT, S_RESP};
  - APB_DATA_W = 32;
  - APB_STRB_W = 4.
- One sub-module, apb_addr_decode (combinational): takes paddr and pwrite; outputs the index and an error flag.
- Register array, counter and FSM stay in the top.

Test Plan:
- WAIT_CYCLES=1: write 0xDEADBEEF to 0x08 (access at T) → pready at T+2 with pslverr=0. Read of 0x08 → prdata=0xDEADBEEF, pslverr=0.
- Read 0x03 → pready with pslverr=1, prdata=0. Write 0x200 with NUM_REGS=32 → pslverr=1 and no register changes.
- Write 0x1234 to 0x7C (counter) → pslverr=1. After 5 completed transfers from reset, reading 0x7C returns 5.
- WAIT_CYCLES=0: back-to-back write then read of 0x10 with 0xA5A5A5A5 → pready at T+1 for each; read returns 0xA5A5A5A5.
- Assert prst in S_WAIT during a write of 0xFFFF0000 to 0x04 → no pready. A subsequent read of 0x04 returns 0; the counter reads 0.
- APB_PSTRB_EN: register 0x0C=0x11223344, then write 0xAABBCCDD with pstrb=4'b0101 → read 0x0C returns 0x11BB33DD.
